clk_period_meter: RTL and testbench

//   Measures a slow periodic signal, e.g. a divided clock from our clock dividers, against clk_in.

---
 rtl/clk_period_meter.sv | 202 ++++++++++++++++++++
 tb/tb_clk_period_meter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/clk_period_meter.sv
// Period / high-time meter for a slow periodic signal, counted in clk_in cycles.
// Optional 4-sample period averaging when PERIOD_AVG_EN is defined.
module clk_period_meter #(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned TIMEOUT = 50000
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             valid,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_MEAS = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic             sync1_q, sync2_q, edge_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d;
    logic             hi_seen_q, hi_seen_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_time_q, high_time_d;
    logic             valid_q, valid_d;
    logic             timeout_q, timeout_d;

    logic             rise_c;
    logic             fall_c;
    logic [CNT_W-1:0] cnt_inc_c;
    logic [CNT_W-1:0] hi_val_c;

`ifdef PERIOD_AVG_EN
    localparam int unsigned SUM_W = CNT_W + 2;

    logic [3:0][CNT_W-1:0] hist_q, hist_d;
    logic [SUM_W-1:0]      sum_q, sum_d;
    logic [2:0]            nmeas_q, nmeas_d;
    logic [SUM_W-1:0]      sum_new_c;
`endif

    // Two-flop synchroniser followed by the edge-detect register.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            edge_q  <= 1'b0;
        end else begin
            sync1_q <= sig_in;
            sync2_q <= sync1_q;
            edge_q  <= sync2_q;
        end
    end

    assign rise_c    = sync2_q & ~edge_q;
    assign fall_c    = ~sync2_q & edge_q;
    assign cnt_inc_c = cnt_q + CNT_ONE;
    assign hi_val_c  = hi_seen_q ? hi_cnt_q : '0;

`ifdef PERIOD_AVG_EN
    // Running sum of the last four raw periods; the oldest drops out as a new one enters.
    assign sum_new_c = sum_q - SUM_W'(hist_q[3]) + SUM_W'(cnt_inc_c);
`endif

    // State and measurement registers.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            hi_cnt_q    <= '0;
            hi_seen_q   <= 1'b0;
            period_q    <= '0;
            high_time_q <= '0;
            valid_q     <= 1'b0;
            timeout_q   <= 1'b0;
`ifdef PERIOD_AVG_EN
            hist_q      <= '0;
            sum_q       <= '0;
            nmeas_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hi_cnt_q    <= hi_cnt_d;
            hi_seen_q   <= hi_seen_d;
            period_q    <= period_d;
            high_time_q <= high_time_d;
            valid_q     <= valid_d;
            timeout_q   <= timeout_d;
`ifdef PERIOD_AVG_EN
            hist_q      <= hist_d;
            sum_q       <= sum_d;
            nmeas_q     <= nmeas_d;
`endif
        end
    end

    // Next-state and measurement logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hi_cnt_d    = hi_cnt_q;
        hi_seen_d   = hi_seen_q;
        period_d    = period_q;
        high_time_d = high_time_q;
        valid_d     = 1'b0;
        timeout_d   = timeout_q;
`ifdef PERIOD_AVG_EN
        hist_d      = hist_q;
        sum_d       = sum_q;
        nmeas_d     = nmeas_q;
`endif

        if (!enable) begin
            state_d   = ST_IDLE;
            cnt_d     = '0;
            hi_cnt_d  = '0;
            hi_seen_d = 1'b0;
`ifdef PERIOD_AVG_EN
            hist_d    = '0;
            sum_d     = '0;
            nmeas_d   = '0;
`endif
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d = ST_ARM;
                end

                ST_ARM: begin
                    if (rise_c) begin
                        state_d   = ST_MEAS;
                        cnt_d     = '0;
                        hi_cnt_d  = '0;
                        hi_seen_d = 1'b0;
                    end
                end

                ST_MEAS: begin
                    cnt_d = cnt_inc_c;
                    if (fall_c && !hi_seen_q) begin
                        hi_cnt_d  = cnt_inc_c;
                        hi_seen_d = 1'b1;
                    end
                    // A rise takes priority over a coincident timeout.
                    if (rise_c) begin
                        cnt_d     = '0;
                        hi_cnt_d  = '0;
                        hi_seen_d = 1'b0;
`ifdef PERIOD_AVG_EN
                        hist_d = {hist_q[2:0], cnt_inc_c};
                        sum_d  = sum_new_c;
                        if (nmeas_q < 3'd4) begin
                            nmeas_d = nmeas_q + 3'd1;
                        end
                        if (nmeas_q >= 3'd3) begin
                            period_d    = CNT_W'(sum_new_c >> 2);
                            high_time_d = hi_val_c;
                            valid_d     = 1'b1;
                            timeout_d   = 1'b0;
                        end
`else
                        period_d    = cnt_inc_c;
                        high_time_d = hi_val_c;
                        valid_d     = 1'b1;
                        timeout_d   = 1'b0;
`endif
                    end else if (cnt_inc_c == TIMEOUT_CNT) begin
                        state_d   = ST_ARM;
                        timeout_d = 1'b1;
                        cnt_d     = '0;
                        hi_cnt_d  = '0;
                        hi_seen_d = 1'b0;
`ifdef PERIOD_AVG_EN
                        hist_d    = '0;
                        sum_d     = '0;
                        nmeas_d   = '0;
`endif
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign period    = period_q;
    assign high_time = high_time_q;
    assign valid     = valid_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_clk_period_meter.sv
// Directed bench for clk_period_meter with hand-computed periods, high times and timeout latency.
module tb_clk_period_meter;

    localparam int unsigned CNT_W       = 16;
    localparam int unsigned TIMEOUT_CYC = 100;
`ifdef PERIOD_AVG_EN
    localparam int AVG_SKIP = 3;
`else
    localparam int AVG_SKIP = 0;
`endif

    logic             clk_in = 1'b0;
    logic             rst_n;
    logic             enable;
    logic             sig_in;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             valid;
    logic             timeout;

    int n_tests = 0;
    int n_fail  = 0;

    clk_period_meter #(
        .CNT_W  (CNT_W),
        .TIMEOUT(TIMEOUT_CYC)
    ) dut (
        .clk_in   (clk_in),
        .rst_n    (rst_n),
        .enable   (enable),
        .sig_in   (sig_in),
        .period   (period),
        .high_time(high_time),
        .valid    (valid),
        .timeout  (timeout)
    );

    initial forever #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Output monitor: logs every valid pulse and the first timeout assertion.
    int         cyc = 0;
    logic       prev_valid = 1'b0;
    logic       prev_to = 1'b0;
    int         to_rise_cyc = -1;
    int         v_cyc[$];
    int         v_per[$];
    int         v_hi[$];
    logic       v_to[$];
    logic       v_prev_to[$];

    always @(posedge clk_in) begin
        cyc++;
        #1;
        if (valid === 1'b1) begin
            check("valid_single_cycle", 32'(prev_valid), 32'd0);
            v_cyc.push_back(cyc);
            v_per.push_back(int'(period));
            v_hi.push_back(int'(high_time));
            v_to.push_back(timeout);
            v_prev_to.push_back(prev_to);
        end
        if (timeout === 1'b1 && prev_to === 1'b0 && to_rise_cyc < 0) to_rise_cyc = cyc;
        prev_valid = valid;
        prev_to    = timeout;
    end

    task automatic cyc_wait(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic wave(input int hi, input int lo, input int n);
        for (int i = 0; i < n; i++) begin
            sig_in = 1'b1;
            cyc_wait(hi);
            sig_in = 1'b0;
            cyc_wait(lo);
        end
    endtask

    task automatic restart();
        enable = 1'b0;
        cyc_wait(3);
        enable = 1'b1;
        cyc_wait(2);
    endtask

    task automatic clear_mon();
        v_cyc.delete();
        v_per.delete();
        v_hi.delete();
        v_to.delete();
        v_prev_to.delete();
        to_rise_cyc = -1;
    endtask

    task automatic check_events(input string tag, input int exp_n, input int exp_per,
                                input int exp_hi);
        check({tag, "_count"}, 32'(v_cyc.size()), 32'(exp_n));
        for (int i = 0; i < v_cyc.size(); i++) begin
            check({tag, "_period"}, 32'(v_per[i]), 32'(exp_per));
            check({tag, "_high"}, 32'(v_hi[i]), 32'(exp_hi));
            check({tag, "_timeout"}, 32'(v_to[i]), 32'd0);
            if (i > 0) check({tag, "_spacing"}, 32'(v_cyc[i] - v_cyc[i-1]), 32'(exp_per));
        end
    endtask

    initial begin
        int c0;
        rst_n  = 1'b0;
        enable = 1'b0;
        sig_in = 1'b0;
        cyc_wait(3);
        check("rst_period", 32'(period), 32'd0);
        check("rst_high", 32'(high_time), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        rst_n = 1'b1;
        cyc_wait(2);

        // Divide-by-4 style square wave: 4 high, 4 low.
        enable = 1'b1;
        cyc_wait(2);
        clear_mon();
        wave(4, 4, 6);
        cyc_wait(4);
        check_events("t1", 5 - AVG_SKIP, 8, 4);

        // Asymmetric duty: 3 high, 7 low.
        restart();
        clear_mon();
        wave(3, 7, 5);
        cyc_wait(4);
        check_events("t2", 4 - AVG_SKIP, 10, 3);

        // Single rise then stuck low: timeout 100 cycles after the detected rise.
        restart();
        clear_mon();
        sig_in = 1'b1;
        c0 = cyc + 1;
        cyc_wait(3);
        sig_in = 1'b0;
        cyc_wait(110);
        check("t3_timeout_cycle", 32'(to_rise_cyc), 32'(c0 + 102));
        check("t3_timeout", 32'(timeout), 32'd1);
        check("t3_period_hold", 32'(period), 32'd10);
        check("t3_high_hold", 32'(high_time), 32'd3);
        check("t3_no_valid", 32'(v_cyc.size()), 32'd0);

        // Toggle resumes from ARM; first valid clears the sticky timeout.
        clear_mon();
        wave(4, 4, 6);
        cyc_wait(4);
        check_events("t3r", 5 - AVG_SKIP, 8, 4);
        if (v_prev_to.size() > 0) check("t3r_to_before_valid", 32'(v_prev_to[0]), 32'd1);
        check("t3r_timeout_clr", 32'(timeout), 32'd0);

        // Disable mid-measurement: no valid, outputs hold.
        restart();
        wave(4, 4, 2);
        clear_mon();
        sig_in = 1'b1;
        cyc_wait(2);
        enable = 1'b0;
        cyc_wait(2);
        sig_in = 1'b0;
        cyc_wait(4);
        wave(3, 7, 3);
        check("t4_no_valid", 32'(v_cyc.size()), 32'd0);
        check("t4_period_hold", 32'(period), 32'd8);
        check("t4_high_hold", 32'(high_time), 32'd4);
        check("t4_timeout_hold", 32'(timeout), 32'd0);
        enable = 1'b1;
        cyc_wait(2);
        clear_mon();
        wave(3, 7, 6);
        cyc_wait(4);
        check_events("t4r", 5 - AVG_SKIP, 10, 3);

        // Asynchronous reset mid-measurement, between clock edges.
        wave(4, 4, 2);
        sig_in = 1'b1;
        cyc_wait(2);
        @(posedge clk_in);
        #2 rst_n = 1'b0;
        #1;
        check("t5_period", 32'(period), 32'd0);
        check("t5_high", 32'(high_time), 32'd0);
        check("t5_valid", 32'(valid), 32'd0);
        check("t5_timeout", 32'(timeout), 32'd0);
        @(posedge clk_in);
        #3 rst_n = 1'b1;
        @(negedge clk_in);
        sig_in = 1'b0;
        clear_mon();
        cyc_wait(25);
        check("t5_no_valid", 32'(v_cyc.size()), 32'd0);
        check("t5_period_after", 32'(period), 32'd0);

`ifdef PERIOD_AVG_EN
        // Averaging: raw periods 8, 8, 12, 12 -> single valid with period 10.
        restart();
        clear_mon();
        wave(4, 4, 2);
        wave(6, 6, 2);
        sig_in = 1'b1;
        cyc_wait(4);
        sig_in = 1'b0;
        cyc_wait(4);
        check("t6_count", 32'(v_cyc.size()), 32'd1);
        check("t6_period", 32'(period), 32'd10);
        check("t6_high", 32'(high_time), 32'd6);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
